// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: PC, ROM read port and a small {pc, inst} FIFO toward decode.
// Optional INST_FETCH_BYPASS_EN presents the ROM word combinationally when the FIFO is empty.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        ce_o,
    output logic [31:0] addr_o,
    input  logic [31:0] inst_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    input  logic        id_ready_i
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic          ce_q, ce_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   mem_q [DEPTH];

    logic        fifo_valid;
    logic        bypass_active;
    logic        bypass_take;
    logic        pop;
    logic        space;
    logic        capture;
    logic [63:0] head;

    assign ce_o   = ce_q;
    assign addr_o = pc_q;
    assign head   = mem_q[rd_ptr_q];

    always_comb begin
        fifo_valid = (count_q != '0);
`ifdef INST_FETCH_BYPASS_EN
        bypass_active = ce_q & (count_q == '0) & ~branch_flag_i;
`else
        bypass_active = 1'b0;
`endif
        bypass_take = bypass_active & id_ready_i;
        pop         = fifo_valid & id_ready_i;
        space       = (count_q < FULL) | pop;
        // A bypassed word is consumed directly, so it must not also be written.
        capture     = ce_q & space & ~branch_flag_i & ~bypass_take;

        if_valid_o = fifo_valid | bypass_active;
        if_pc_o    = '0;
        if_inst_o  = '0;
        if (bypass_active) begin
            if_pc_o   = pc_q;
            if_inst_o = inst_i;
        end else if (fifo_valid) begin
            if_pc_o   = head[63:32];
            if_inst_o = head[31:0];
        end
    end

    always_comb begin
        pc_d     = pc_q;
        ce_d     = 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (branch_flag_i) begin
            pc_d     = branch_target_i & ~32'h0000_0003;
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (capture || bypass_take) begin
                pc_d = pc_q + 32'd4;
            end
            if (capture) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (capture && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !capture) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            ce_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            ce_q     <= ce_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= {pc_q, inst_i};
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: a default-PC instance and a wrap-around instance.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        id_ready = 1'b1;

    logic        ce, if_valid;
    logic [31:0] addr, inst, if_pc, if_inst;

    logic        w_ready = 1'b1;
    logic        w_branch = 1'b0;
    logic [31:0] w_target = '0;
    logic        w_ce, w_valid;
    logic [31:0] w_addr, w_inst, w_pc, w_inst_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign inst   = rom(addr);
    assign w_inst = rom(w_addr);

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .branch_flag_i(branch_flag), .branch_target_i(branch_target),
        .ce_o(ce), .addr_o(addr), .inst_i(inst),
        .if_valid_o(if_valid), .if_pc_o(if_pc), .if_inst_o(if_inst),
        .id_ready_i(id_ready)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
        .clk(clk), .rst(rst),
        .branch_flag_i(w_branch), .branch_target_i(w_target),
        .ce_o(w_ce), .addr_o(w_addr), .inst_i(w_inst),
        .if_valid_o(w_valid), .if_pc_o(w_pc), .if_inst_o(w_inst_o),
        .id_ready_i(w_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ce",     32'(ce), 32'd0);
        check("rst_valid",  32'(if_valid), 32'd0);
        check("rst_pc_o",   if_pc, 32'h0);
        check("rst_inst_o", if_inst, 32'h0);
        check("rst_addr",   addr, 32'h0);
        check("rst_w_addr", w_addr, 32'hFFFF_FFF8);
        check("rst_w_valid", 32'(w_valid), 32'd0);

        rst = 1'b1;
        @(negedge clk);
        check("e0_ce", 32'(ce), 32'd1);
        check("e0_addr", addr, 32'h0);

`ifdef INST_FETCH_BYPASS_EN
        for (int k = 0; k < 6; k++) begin
            check("byp_valid", 32'(if_valid), 32'd1);
            check("byp_pc", if_pc, 32'(4 * k));
            check("byp_inst", if_inst, 32'h1000_0000 + 32'(k));
            check("byp_w_pc", w_pc, 32'hFFFF_FFF8 + 32'(4 * k));
            @(negedge clk);
        end
        id_ready = 1'b0;
        check("byp_stall_pc", if_pc, 32'd24);
        @(negedge clk);
        check("byp_cap_valid", 32'(if_valid), 32'd1);
        check("byp_cap_pc", if_pc, 32'd24);
        check("byp_cap_inst", if_inst, 32'h1000_0006);
        check("byp_cap_addr", addr, 32'd28);
`else
        check("e0_valid", 32'(if_valid), 32'd0);
        check("e0_w_addr", w_addr, 32'hFFFF_FFF8);

        // Sequential fetch, one word per cycle; wrap instance runs alongside.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("seq_valid", 32'(if_valid), 32'd1);
            check("seq_pc", if_pc, 32'(4 * k));
            check("seq_inst", if_inst, 32'h1000_0000 + 32'(k));
            check("seq_addr", addr, 32'(4 * k + 4));
            check("wrap_pc", w_pc, 32'hFFFF_FFF8 + 32'(4 * k));
        end

        // Partly fill, then drop reset between edges.
        id_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("fill_valid", 32'(if_valid), 32'd1);
        check("fill_pc", if_pc, 32'd20);
        check("fill_addr", addr, 32'd32);
        #2 rst = 1'b0;
        #1;
        check("arst_ce", 32'(ce), 32'd0);
        check("arst_valid", 32'(if_valid), 32'd0);
        check("arst_addr", addr, 32'h0);
        check("arst_pc_o", if_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart_ce", 32'(ce), 32'd1);
        check("restart_addr", addr, 32'h0);

        // Three words queued, then branch with a simultaneous pop.
        repeat (3) @(negedge clk);
        check("pre_br_pc", if_pc, 32'h0);
        check("pre_br_addr", addr, 32'd12);
        branch_flag = 1'b1;
        branch_target = 32'h0000_0103;
        id_ready = 1'b1;
        @(negedge clk);
        check("br_valid", 32'(if_valid), 32'd0);
        check("br_addr", addr, 32'h0000_0100);
        branch_flag = 1'b0;
        @(negedge clk);
        check("br_tgt_valid", 32'(if_valid), 32'd1);
        check("br_tgt_pc", if_pc, 32'h0000_0100);
        check("br_tgt_inst", if_inst, 32'h1000_0040);
        check("br_tgt_addr", addr, 32'h0000_0104);
        @(negedge clk);
        check("br_next_pc", if_pc, 32'h0000_0104);

        // Backpressure from a fresh reset.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        id_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("bp_addr", addr, 32'd16);
        check("bp_valid", 32'(if_valid), 32'd1);
        check("bp_pc", if_pc, 32'h0);
        id_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("bp_rel_pc", if_pc, 32'(4 * i));
            check("bp_rel_inst", if_inst, 32'h1000_0000 + 32'(i));
            check("bp_rel_addr", addr, 32'(16 + 4 * i));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
